// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with programmable terminal value, parallel load,
// wrap or saturate at the boundary, and wrap-pulse / sticky-overflow status.
module updown_mod_counter #(
  parameter int unsigned      WIDTH    = 7,
  parameter logic [WIDTH-1:0] MOD_MAX  = {WIDTH{1'b1}},
  parameter bit               SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             clr_ovf,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrap,
  output logic             ovf_sticky
);

  logic [WIDTH-1:0] q_d, q_q;
  logic             wrap_d, wrap_q;
  logic             ovf_d, ovf_q;
  logic [WIDTH-1:0] load_clamped;
  logic             at_max, at_zero, boundary;

  // A full-range MOD_MAX cannot be exceeded, so the clamp compare is omitted.
  if (MOD_MAX == {WIDTH{1'b1}}) begin : g_no_clamp
    assign load_clamped = load_val;
  end else begin : g_clamp
    assign load_clamped = (load_val > MOD_MAX) ? MOD_MAX : load_val;
  end

  assign at_max   = (q_q == MOD_MAX);
  assign at_zero  = (q_q == '0);
  assign boundary = en & ((up & at_max) | (~up & at_zero));

  always_comb begin
    q_d    = q_q;
    wrap_d = 1'b0;
    ovf_d  = ovf_q & ~clr_ovf;
    if (load) begin
      q_d = load_clamped;
    end else if (en) begin
      if (boundary) begin
        // Event sets the sticky flag even when clr_ovf is raised in the same cycle.
        wrap_d = 1'b1;
        ovf_d  = 1'b1;
        if (!SATURATE) begin
          q_d = up ? '0 : MOD_MAX;
        end
      end else if (up) begin
        q_d = q_q + WIDTH'(1);
      end else begin
        q_d = q_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q_q    <= '0;
      wrap_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      q_q    <= q_d;
      wrap_q <= wrap_d;
      ovf_q  <= ovf_d;
    end
  end

  assign q          = q_q;
  assign tc         = boundary;
  assign wrap       = wrap_q;
  assign ovf_sticky = ovf_q;

endmodule
